// File: rtl/count_pkg.sv
// Shared definitions for the counter family: widths common to the up-count
// logic and this down-counter, plus the down-counter state type.
package count_pkg;

  localparam int COUNT_W    = 16;
  localparam int PRESCALE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/count_prescaler.sv
// Prescaler for the down-counter: counts enabled cycles and strobes tick
// once every limit+1 of them, wrapping back to zero on the strobe.
module count_prescaler
  import count_pkg::*;
#(
  parameter int LIMIT_W = PRESCALE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic [LIMIT_W-1:0] limit,
  output logic               tick
);

  logic [LIMIT_W-1:0] ps_cnt;

  assign tick = run && (ps_cnt == limit);

  // clear outranks run so an abort on a tick edge still restarts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
    end else if (clear) begin
      ps_cnt <= '0;
    end else if (run) begin
      if (tick) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_down.sv
// Loadable down-counter/timer: start value taken over a valid/ready handshake,
// counts on prescaled ticks, strobes tc_pulse at expiry and optionally reloads.
module count_down
  import count_pkg::*;
#(
  parameter int WIDTH      = COUNT_W,
  parameter int PRESCALE_W = count_pkg::PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  enable,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse
);

  state_t                state;
  state_t                state_next;
  logic [WIDTH-1:0]      count_next;
  logic [WIDTH-1:0]      reload_reg;
  logic                  ar_reg;
  logic [PRESCALE_W-1:0] ps_reg;
  logic                  tc_next;
  logic                  load_fire;
  logic                  tick;

  assign load_ready = (state != RUN);
  assign busy       = (state == RUN);
  // abort suppresses a load offered on the same edge
  assign load_fire  = load_valid && load_ready && !abort;

  count_prescaler #(
    .LIMIT_W (PRESCALE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (abort || load_fire),
    .run   (busy && enable),
    .limit (ps_reg),
    .tick  (tick)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    tc_next    = 1'b0;
    if (abort) begin
      state_next = IDLE;
      count_next = '0;
    end else if (load_fire) begin
      state_next = RUN;
      count_next = load_value;
    end else if (tick) begin
      if (count != '0) begin
        count_next = count - 1'b1;
      end else begin
        tc_next = 1'b1;
        if (ar_reg) begin
          count_next = reload_reg;
        end else begin
          state_next = DONE;
        end
      end
    end
  end

  // load parameters are captured only on the handshake edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      tc_pulse   <= 1'b0;
      reload_reg <= '0;
      ar_reg     <= 1'b0;
      ps_reg     <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      tc_pulse <= tc_next;
      if (load_fire) begin
        reload_reg <= load_value;
        ar_reg     <= auto_reload;
        ps_reg     <= prescale;
      end
    end
  end

endmodule

// File: tb/tb_count_down.sv
// Randomised scoreboard bench for count_down: expiry edges are predicted from
// enabled-cycle arithmetic and matched against tc_pulse by a separate monitor.
module tb_count_down;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        auto_reload;
  logic [7:0]  prescale;
  logic        enable;
  logic        abort;
  logic [15:0] count;
  logic        busy;
  logic        tc_pulse;

  int edgeNum = 0;
  int total   = 0;
  int bad     = 0;
  int tcQueue[$];
  int expEdge;
  int baseEdge;
  logic [15:0] rn;
  logic [7:0]  rp;
  logic        rar;

  count_down dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .enable      (enable),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .tc_pulse    (tc_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeNum <= edgeNum + 1;

  // every observed expiry strobe must match the oldest predicted expiry edge
  always @(negedge clk) begin
    if (tc_pulse) begin
      total++;
      if (tcQueue.size() == 0) begin
        bad++;
        $display("[TB] FAIL tc_unexpected at edge %0d: got tc_pulse=1, required 0", edgeNum);
      end else begin
        expEdge = tcQueue.pop_front();
        if (expEdge != edgeNum) begin
          bad++;
          $display("[TB] FAIL tc_edge: got tc_pulse at edge %0d, required edge %0d", edgeNum, expEdge);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] expCount, input logic expBusy);
    total++;
    if (count !== expCount || busy !== expBusy || load_ready !== !expBusy) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got count=%0d busy=%b ready=%b, required count=%0d busy=%b ready=%b",
               name, edgeNum, count, busy, load_ready, expCount, expBusy, !expBusy);
    end
  endtask

  // gateMode: 0 = enable always high, 1 = five-cycle gap, 2 = random gating
  task automatic applyStimulus(input logic [15:0] n, input logic [7:0] p, input logic ar,
                               input int gateMode, input int runEdges);
    int e0;
    int m;
    int period;
    int en;
    int ticks;
    logic [15:0] expCount;
    logic expBusy;
    period = (int'(n) + 1) * (int'(p) + 1);
    @(posedge clk); #1;
    load_valid  = 1'b1;
    load_value  = n;
    prescale    = p;
    auto_reload = ar;
    enable      = 1'b1;
    @(posedge clk); #1;
    e0          = edgeNum;
    load_valid  = 1'b0;
    load_value  = 16'($urandom);
    prescale    = 8'($urandom);
    auto_reload = 1'($urandom);
    checkOutput("load", n, 1'b1);
    m = 0;
    for (int j = 1; j <= runEdges; j++) begin
      case (gateMode)
        1:       en = (j < 4 || j >= 9) ? 1 : 0;
        2:       en = ($urandom_range(0, 3) != 0) ? 1 : 0;
        default: en = 1;
      endcase
      if (en != 0) begin
        m++;
        if (ar ? (m % period == 0) : (m == period)) tcQueue.push_back(e0 + j);
      end
      enable = (en != 0);
      @(posedge clk); #1;
      if (ar) begin
        ticks   = (m % period) / (int'(p) + 1);
        expBusy = 1'b1;
      end else begin
        ticks   = m / (int'(p) + 1);
        expBusy = (m < period);
      end
      expCount = (ticks >= int'(n)) ? 16'd0 : 16'(int'(n) - ticks);
      checkOutput("run", expCount, expBusy);
    end
    abort  = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort", 16'd0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("post_abort_idle", 16'd0, 1'b0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_value  = '0;
    auto_reload = 1'b0;
    prescale    = '0;
    enable      = 1'b0;
    abort       = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      checkOutput("reset_idle", 16'd0, 1'b0);
    end

    applyStimulus(16'd3, 8'd0, 1'b0, 0, 6);
    applyStimulus(16'd2, 8'd3, 1'b0, 0, 14);
    applyStimulus(16'd2, 8'd3, 1'b0, 1, 20);
    applyStimulus(16'd1, 8'd0, 1'b1, 0, 7);
    applyStimulus(16'd0, 8'd0, 1'b0, 0, 3);
    applyStimulus(16'd0, 8'd0, 1'b1, 0, 5);

    repeat (20) begin
      rn  = 16'($urandom_range(0, 12));
      rp  = 8'($urandom_range(0, 3));
      rar = 1'($urandom_range(0, 1));
      applyStimulus(rn, rp, rar, 2, 2 * (int'(rn) + 1) * (int'(rp) + 1) + 8);
    end

    // abort and load offered together while idle: no load
    @(posedge clk); #1;
    load_valid = 1'b1; load_value = 16'd7; prescale = 8'd0; auto_reload = 1'b0;
    abort = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; abort = 1'b0;
    checkOutput("abort_load_idle", 16'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("abort_load_after", 16'd0, 1'b0);

    // load_valid held through RUN: next load lands on the edge after expiry
    load_valid = 1'b1; load_value = 16'd2; prescale = 8'd0; auto_reload = 1'b0;
    @(posedge clk); #1;
    baseEdge   = edgeNum;
    load_value = 16'd5;
    tcQueue.push_back(baseEdge + 3);
    checkOutput("held_load", 16'd2, 1'b1);
    @(posedge clk); #1; checkOutput("held_run1", 16'd1, 1'b1);
    @(posedge clk); #1; checkOutput("held_run2", 16'd0, 1'b1);
    @(posedge clk); #1; checkOutput("held_done", 16'd0, 1'b0);
    @(posedge clk); #1; checkOutput("held_accept", 16'd5, 1'b1);
    load_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("held_abort", 16'd0, 1'b0);

    // synchronous reset mid-run
    load_valid = 1'b1; load_value = 16'd10; prescale = 8'd0; auto_reload = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    checkOutput("rst_load", 16'd10, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_run", 16'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rst_after", 16'd0, 1'b0);

    applyStimulus(16'hFFFF, 8'd0, 1'b0, 0, 65538);

    repeat (4) @(posedge clk);
    total++;
    if (tcQueue.size() != 0) begin
      bad++;
      $display("[TB] FAIL tc_missing: got %0d predicted expiries never seen, required 0", tcQueue.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
